// File: rtl/symbol_splitter_if.sv
// -----------------------------------------------------------------------------
// symbol_splitter_if
//   Byte handshake between the payload source and symbol_splitter.
//   data_in    : payload byte (source -> splitter)
//   data_valid : data_in is valid (source -> splitter)
//   data_ready : splitter accepts data_in this cycle (splitter -> source)
//   Modports: master = payload source, slave = symbol_splitter.
// -----------------------------------------------------------------------------
interface symbol_splitter_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/symbol_splitter.sv
// -----------------------------------------------------------------------------
// symbol_splitter
//   Transmit-side stage ahead of the symbol bit-serialiser. Accepts payload
//   bytes over a valid/ready handshake and slices each byte MSB first into
//   per-symbol bit groups (1 bit in BPSK, N bits otherwise). Each group is
//   presented in the N LSBs of an M-bit word on every sym_en strobe; BPSK
//   bits are replicated across the N LSBs. A strobe with no data emits
//   IDLE_SYM and pulses underrun.
//
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     sym_en    : one-cycle symbol strobe
//     is_bpsk   : mode, latched at byte load (1 = one bit per symbol)
//     byte_if   : slave side of data_in / data_valid / data_ready
//     sym_out   : current symbol word, held between strobes, [M-1:N] = 0
//     sym_valid : one-cycle pulse when sym_out carries payload bits
//     underrun  : one-cycle pulse when a strobe finds no data
//
//   Optional build macro SYMBOL_SPLITTER_SCRAMBLE_EN: XOR every sliced payload
//   bit with a 7-bit LFSR (x^7 + x^4 + 1, seed 7'h7F) stepped once per bit.
// -----------------------------------------------------------------------------
module symbol_splitter #(
   parameter int unsigned  N        = 2,
   parameter int unsigned  M        = 8,
   parameter logic [N-1:0] IDLE_SYM = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sym_en,
   input  logic             is_bpsk,
   symbol_splitter_if.slave byte_if,
   output logic [M-1:0]     sym_out,
   output logic             sym_valid,
   output logic             underrun
);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [3:0] BPS_MULTI = 4'(N);

   state_t       state_q, state_d;
   logic [7:0]   shreg_q, shreg_d;
   logic [3:0]   rem_q, rem_d;
   logic         mode_q, mode_d;
   logic [M-1:0] sym_q, sym_d;
   logic         valid_q, valid_d;
   logic         under_q, under_d;

   logic [3:0]   bps_q;
   logic         load;
   logic         pay_strobe;
   logic [7:0]   src;
   logic         src_mode;
   logic [3:0]   src_bps;
   logic [7:0]   sliced;
   logic [M-1:0] pay_word;
   logic [M-1:0] idle_word;

   assign bps_q = mode_q ? 4'd1 : BPS_MULTI;

   // rem == bps means the strobe about to happen drains the byte, so the next
   // byte can be taken in the same cycle without an idle symbol.
   assign byte_if.data_ready = (state_q == EMPTY) | (sym_en & (rem_q == bps_q));
   assign load               = byte_if.data_valid & byte_if.data_ready;

   // A strobe that produces payload: either HOLD, or EMPTY with a same-cycle load.
   assign pay_strobe = sym_en & ((state_q == HOLD) | load);

   // In EMPTY the first symbol comes straight from data_in with the incoming
   // mode; otherwise from the shift register with the latched mode.
   always_comb begin
      src      = (state_q == EMPTY) ? byte_if.data_in : shreg_q;
      src_mode = (state_q == EMPTY) ? is_bpsk : mode_q;
      src_bps  = src_mode ? 4'd1 : BPS_MULTI;
   end

`ifdef SYMBOL_SPLITTER_SCRAMBLE_EN
   logic [6:0] lfsr_q, lfsr_d, lfsr_adv;
   logic [7:0] keystream;

   // Keystream is MSB-aligned with the bits about to be sliced; lfsr_adv is
   // the register value after src_bps steps.
   always_comb begin
      keystream = '0;
      lfsr_adv  = lfsr_q;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < 32'(src_bps)) begin
            keystream[3'(7 - i)] = lfsr_adv[6];
            lfsr_adv             = {lfsr_adv[5:0], lfsr_adv[6] ^ lfsr_adv[3]};
         end
      end
   end

   assign sliced = src ^ keystream;

   // Underrun strobes leave the LFSR untouched.
   assign lfsr_d = pay_strobe ? lfsr_adv : lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 7'h7F;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign sliced = src;
`endif

   always_comb begin
      pay_word            = '0;
      idle_word           = '0;
      idle_word[N-1:0]    = IDLE_SYM;
      if (src_mode) begin
         pay_word[N-1:0] = {N{sliced[7]}};
      end else begin
         pay_word[N-1:0] = sliced[7 -: N];
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      sym_d   = sym_q;
      valid_d = 1'b0;
      under_d = 1'b0;

      case (state_q)
         EMPTY: begin
            if (load) begin
               mode_d = is_bpsk;
               if (sym_en) begin
                  sym_d   = pay_word;
                  valid_d = 1'b1;
                  shreg_d = src << src_bps;
                  rem_d   = 4'd8 - src_bps;
               end else begin
                  shreg_d = byte_if.data_in;
                  rem_d   = 4'd8;
               end
            end else if (sym_en) begin
               sym_d   = idle_word;
               under_d = 1'b1;
            end
         end
         HOLD: begin
            if (sym_en) begin
               sym_d   = pay_word;
               valid_d = 1'b1;
               if (load) begin
                  shreg_d = byte_if.data_in;
                  rem_d   = 4'd8;
                  mode_d  = is_bpsk;
               end else begin
                  shreg_d = shreg_q << bps_q;
                  rem_d   = rem_q - bps_q;
               end
            end
         end
         default: ;
      endcase

      // State tracks rem: covers the drain to EMPTY and an N=8 byte that is
      // fully consumed by the strobe it was loaded on.
      state_d = (rem_d == 4'd0) ? EMPTY : HOLD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         shreg_q <= '0;
         rem_q   <= '0;
         mode_q  <= 1'b0;
         sym_q   <= '0;
         valid_q <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         sym_q   <= sym_d;
         valid_q <= valid_d;
         under_q <= under_d;
      end
   end

   assign sym_out   = sym_q;
   assign sym_valid = valid_q;
   assign underrun  = under_q;

endmodule

// File: tb/tb_symbol_splitter.sv
// -----------------------------------------------------------------------------
// tb_symbol_splitter
//   Directed scenarios followed by randomized traffic for symbol_splitter
//   (N=2, M=8, IDLE_SYM=2'b01). Expected values come from a queue of pending
//   symbol words built per byte.
// -----------------------------------------------------------------------------
module tb_symbol_splitter;

   localparam int unsigned  N    = 2;
   localparam int unsigned  M    = 8;
   localparam logic [N-1:0] IDLE = 2'b01;

   logic         clk = 1'b0;
   logic         rst;
   logic         sym_en;
   logic         is_bpsk;
   logic [M-1:0] sym_out;
   logic         sym_valid;
   logic         underrun;

   symbol_splitter_if bif ();

   symbol_splitter #(
      .N        (N),
      .M        (M),
      .IDLE_SYM (IDLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_en    (sym_en),
      .is_bpsk   (is_bpsk),
      .byte_if   (bif),
      .sym_out   (sym_out),
      .sym_valid (sym_valid),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   int unsigned  vectors     = 0;
   int unsigned  miscompares = 0;
   logic [M-1:0] sq [$];
   logic [M-1:0] exp_sym   = '0;
   logic         exp_valid = 1'b0;
   logic         exp_und   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Split a byte into its symbol words, MSB group first.
   function automatic void push_byte(input logic [7:0] b, input logic bpsk);
      int unsigned  bits;
      int unsigned  grp;
      logic [M-1:0] w;
      bits = bpsk ? 1 : N;
      for (int unsigned i = 0; i < 8 / bits; i++) begin
         grp = (32'(b) >> (8 - bits * (i + 1))) & ((32'd1 << bits) - 1);
         if (bpsk) w = (grp != 0) ? M'((32'd1 << N) - 1) : '0;
         else      w = M'(grp);
         sq.push_back(w);
      end
   endfunction

   task automatic step(input logic se, input logic dv, input logic [7:0] din,
                       input logic bp, output bit took);
      bit was_empty;
      bit ready;
      bit load;
      sym_en         = se;
      bif.data_valid = dv;
      bif.data_in    = din;
      is_bpsk        = bp;
      #1;
      was_empty = (sq.size() == 0);
      ready     = was_empty || (se && sq.size() == 1);
      if (!rst) chk("data_ready", 32'(bif.data_ready), 32'(ready));
      load = dv && ready && !rst;
      if (rst) begin
         sq.delete();
         exp_sym   = '0;
         exp_valid = 1'b0;
         exp_und   = 1'b0;
      end else begin
         exp_valid = 1'b0;
         exp_und   = 1'b0;
         if (load && was_empty) push_byte(din, bp);
         if (se) begin
            if (sq.size() > 0) begin
               exp_sym   = sq.pop_front();
               exp_valid = 1'b1;
            end else begin
               exp_sym = M'(IDLE);
               exp_und = 1'b1;
            end
         end
         if (load && !was_empty) push_byte(din, bp);
      end
      @(posedge clk);
      #1;
      chk("sym_out",   32'(sym_out),   32'(exp_sym));
      chk("sym_valid", 32'(sym_valid), 32'(exp_valid));
      chk("underrun",  32'(underrun),  32'(exp_und));
      took = load;
   endtask

   initial begin
      bit           took;
      logic [M-1:0] b4_exp [4];
      logic [7:0]   a5;
      logic [7:0]   src_byte;
      bit           src_valid;
      bit           src_bpsk;

      b4_exp    = '{8'h02, 8'h03, 8'h01, 8'h00};
      a5        = 8'hA5;
      src_byte  = '0;
      src_valid = 1'b0;
      src_bpsk  = 1'b0;

      // Reset wins over a same-cycle strobe and load.
      rst = 1'b1;
      step(1'b1, 1'b1, 8'hFF, 1'b0, took);
      rst = 1'b0;
      chk("reset_sym_out", 32'(sym_out), 32'h0);

      // QPSK 8'hB4 loaded without strobe, then 4 strobes.
      step(1'b0, 1'b1, 8'hB4, 1'b0, took);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, took);
         chk("b4_sym", 32'(sym_out), 32'(b4_exp[i]));
      end

      // BPSK 8'hA5; is_bpsk dropped mid-byte must not matter.
      step(1'b0, 1'b1, 8'hA5, 1'b1, took);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, took);
         chk("a5_bpsk", 32'(sym_out), a5[7 - i] ? 32'h3 : 32'h0);
         chk("a5_no_underrun", 32'(underrun), 32'h0);
      end

      // Back-to-back 8'h0F then 8'hF0, data_valid held until accepted.
      step(1'b0, 1'b1, 8'h0F, 1'b0, took);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i < 4) ? 1'b1 : 1'b0, 8'hF0, 1'b0, took);
         chk("b2b_valid", 32'(sym_valid), 32'h1);
      end

      // No data: three underruns with the idle symbol.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, took);
         chk("idle_underrun", 32'(underrun), 32'h1);
         chk("idle_sym", 32'(sym_out), 32'(IDLE));
      end

      // Load coinciding with a strobe in EMPTY: first symbol same cycle.
      step(1'b1, 1'b1, 8'h6C, 1'b0, took);
      chk("empty_load_sym", 32'(sym_out), 32'h1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, took);

      // Reset mid-byte after two QPSK symbols of 8'hFF.
      step(1'b0, 1'b1, 8'hFF, 1'b0, took);
      step(1'b1, 1'b0, 8'h00, 1'b0, took);
      step(1'b1, 1'b0, 8'h00, 1'b0, took);
      rst = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b0, took);
      rst = 1'b0;
      chk("rst_mid_sym_out", 32'(sym_out), 32'h0);
      step(1'b1, 1'b0, 8'h00, 1'b0, took);
      chk("rst_mid_underrun", 32'(underrun), 32'h1);

      // Randomized traffic from a source that holds each byte until taken.
      for (int i = 0; i < 800; i++) begin
         if (!src_valid && ($urandom_range(1, 0) != 0)) begin
            src_byte  = 8'($urandom);
            src_bpsk  = ($urandom_range(1, 0) != 0);
            src_valid = 1'b1;
         end
         rst = ($urandom_range(99, 0) == 0);
         step(($urandom_range(2, 0) == 0), src_valid, src_byte, src_bpsk, took);
         if (took) src_valid = 1'b0;
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
